// File: rtl/alu_pipe_param.sv
// Parameterised ALU: single-cycle logic/add ops plus multi-cycle multiply ops.
// Operands are captured on acceptance; results hold until the next completion.
module alu_pipe_param #(
  parameter int WIDTH    = 8,
  parameter int MULT_LAT = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [3:0]         opcode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               done,
  output logic               busy,
  output logic               err,
  output logic [2*WIDTH-1:0] result
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = 4;
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] LOAD = CW'(MULT_LAT - 1);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("alu_pipe_param: WIDTH %0d outside 2..32", WIDTH);
  end
  if (MULT_LAT < 2 || MULT_LAT > 8) begin : g_bad_lat
    $error("alu_pipe_param: MULT_LAT %0d outside 2..8", MULT_LAT);
  end

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic [3:0]        op_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              accept;
  logic              fire_now;
  logic              fire_exec;
  logic [RW-1:0]     res_now;
  logic              err_now;
  logic [RW-1:0]     res_exec;

  function automatic logic is_multi(input logic [3:0] op);
    return (op == 4'h4) || (op >= 4'h9 && op <= 4'hC);
  endfunction

  function automatic logic [RW:0] calc_single(
    input logic [3:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [RW-1:0] ax;
    logic [RW-1:0] bx;
    logic [RW-1:0] r;
    logic          e;
    ax = RW'(a);
    bx = RW'(b);
    r  = '0;
    e  = 1'b0;
    unique case (op)
      4'h0:    r = '0;
      4'h1:    r = ax + bx;
      4'h2:    r = ax & bx;
      4'h3:    r = ax - bx;
      4'h5:    r = ax ^ bx;
      4'h6:    r = ax | bx;
      4'h7:    r = RW'({a, 1'b0});
      4'h8:    r = RW'(a >> 1);
      4'hD,
      4'hE,
      4'hF:    e = 1'b1;
      default: r = '0;
    endcase
    return {e, r};
  endfunction

  function automatic logic [RW-1:0] calc_multi(
    input logic [3:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [RW-1:0] ax;
    logic [RW-1:0] bx;
    logic [RW-1:0] p;
    logic [RW-1:0] r;
    ax = RW'(a);
    bx = RW'(b);
    p  = ax * bx;
    r  = '0;
    unique case (op)
      4'h4:    r = p;
      4'h9:    r = p - ax;
      4'hA:    r = (p << 2) - ax;
      4'hB:    r = p + ax;
      4'hC:    r = (ax << 1) + ax;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Single-cycle ops read live inputs; multi-cycle ops read captured copies.
  assign {err_now, res_now} = calc_single(opcode, A, B);
  assign res_exec           = calc_multi(op_q, a_q, b_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    fire_now  = 1'b0;
    fire_exec = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (is_multi(opcode)) begin
            state_d = EXEC;
            cnt_d   = LOAD;
          end else begin
            fire_now = 1'b1;
          end
        end
      end
      EXEC: begin
        cnt_d = cnt_q - ONE;
        if (cnt_q == ONE) begin
          state_d   = IDLE;
          fire_exec = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (accept) begin
      op_q <= opcode;
      a_q  <= A;
      b_q  <= B;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
    end else begin
      done <= fire_now | fire_exec;
      if (fire_now) begin
        err    <= err_now;
        result <= res_now;
      end else if (fire_exec) begin
        err    <= 1'b0;
        result <= res_exec;
      end
    end
  end

  assign busy = (state_q == EXEC);

endmodule

// File: tb/tb_alu_pipe_param.sv
// Bench for alu_pipe_param: timestamp-based transaction model for two
// configurations (8/3 and 16/5) plus directed literal checks.
module tb_alu_pipe_param;

  logic        clk = 1'b0;
  logic        reset_n;

  logic        st8;
  logic [3:0]  op8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        d8;
  logic        bz8;
  logic        e8;
  logic [15:0] r8;

  logic        st16;
  logic [3:0]  op16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        d16;
  logic        bz16;
  logic        e16;
  logic [31:0] r16;

  int n_chk  = 0;
  int n_fail = 0;

  alu_pipe_param #(.WIDTH(8), .MULT_LAT(3)) u8 (
    .clk(clk), .reset_n(reset_n), .start(st8), .opcode(op8),
    .A(a8), .B(b8), .done(d8), .busy(bz8), .err(e8), .result(r8)
  );

  alu_pipe_param #(.WIDTH(16), .MULT_LAT(5)) u16 (
    .clk(clk), .reset_n(reset_n), .start(st16), .opcode(op16),
    .A(a16), .B(b16), .done(d16), .busy(bz16), .err(e16), .result(r16)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic   pend;
    int     fin;
    longint fres;
    logic   ferr;
    logic   done;
    logic   busy;
    logic   err;
    longint res;
    int     cyc;
  } mdl_t;

  mdl_t m8  = '0;
  mdl_t m16 = '0;

  function automatic logic is_mult(logic [3:0] op);
    return op inside {4'd4, 4'd9, 4'd10, 4'd11, 4'd12};
  endfunction

  function automatic longint ref_res(int w, logic [3:0] op,
                                     longint a, longint b);
    longint r;
    case (op)
      4'd1:    r = a + b;
      4'd2:    r = a & b;
      4'd3:    r = a - b;
      4'd4:    r = a * b;
      4'd5:    r = a ^ b;
      4'd6:    r = a | b;
      4'd7:    r = a * 2;
      4'd8:    r = a / 2;
      4'd9:    r = a * b - a;
      4'd10:   r = 4 * a * b - a;
      4'd11:   r = a * b + a;
      4'd12:   r = 3 * a;
      default: r = 0;
    endcase
    return r & ((longint'(1) << (2 * w)) - 1);
  endfunction

  // Each accepted op finishes at a known cycle; busy means "one is pending".
  function automatic mdl_t step(mdl_t m, int w, int lat, logic st,
                                logic [3:0] op, longint a, longint b);
    mdl_t n;
    int   l;
    n      = m;
    n.cyc  = m.cyc + 1;
    n.done = 1'b0;
    if (m.pend) begin
      if (m.fin == n.cyc) begin
        n.pend = 1'b0;
        n.done = 1'b1;
        n.res  = m.fres;
        n.err  = m.ferr;
      end
    end else if (st) begin
      l = is_mult(op) ? lat : 1;
      if (l == 1) begin
        n.done = 1'b1;
        n.res  = ref_res(w, op, a, b);
        n.err  = (op >= 4'd13);
      end else begin
        n.pend = 1'b1;
        n.fin  = n.cyc + l - 1;
        n.fres = ref_res(w, op, a, b);
        n.ferr = 1'b0;
      end
    end
    n.busy = n.pend;
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m8  <= '0;
      m16 <= '0;
    end else begin
      m8  <= step(m8, 8, 3, st8, op8, longint'(a8), longint'(b8));
      m16 <= step(m16, 16, 5, st16, op16, longint'(a16), longint'(b16));
    end
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("done8", 64'(d8), 64'(m8.done));
    chk("busy8", 64'(bz8), 64'(m8.busy));
    chk("err8", 64'(e8), 64'(m8.err));
    chk("res8", 64'(r8), m8.res);
    chk("done16", 64'(d16), 64'(m16.done));
    chk("busy16", 64'(bz16), 64'(m16.busy));
    chk("err16", 64'(e16), 64'(m16.err));
    chk("res16", 64'(r16), m16.res);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic put8(logic s, logic [3:0] op, logic [7:0] a, logic [7:0] b);
    st8 = s;
    op8 = op;
    a8  = a;
    b8  = b;
  endtask

  task automatic put16(logic s, logic [3:0] op,
                       logic [15:0] a, logic [15:0] b);
    st16 = s;
    op16 = op;
    a16  = a;
    b16  = b;
  endtask

  // Issue one op; optionally keep poking start while busy. Returns the
  // number of cycles until done (0 on timeout) and busy cycles seen.
  task automatic go8(logic [3:0] op, logic [7:0] a, logic [7:0] b,
                     logic poke, output int lat, output int nb);
    put8(1'b1, op, a, b);
    lat = 0;
    nb  = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (bz8) nb++;
      if (d8) begin
        lat = k;
        break;
      end
      put8(poke, 4'd1, 8'($urandom), 8'($urandom));
    end
    put8(1'b0, 4'd0, 8'($urandom), 8'($urandom));
  endtask

  task automatic go16(logic [3:0] op, logic [15:0] a, logic [15:0] b,
                      output int lat, output int nb);
    put16(1'b1, op, a, b);
    lat = 0;
    nb  = 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (bz16) nb++;
      if (d16) begin
        lat = k;
        break;
      end
      put16(1'b1, 4'd1, 16'($urandom), 16'($urandom));
    end
    put16(1'b0, 4'd0, 16'($urandom), 16'($urandom));
  endtask

  initial begin
    int lat;
    int nb;
    reset_n = 1'b0;
    put8(1'b0, 4'd0, 8'd0, 8'd0);
    put16(1'b0, 4'd0, 16'd0, 16'd0);
    tick();
    tick();
    chk("rst_done8", 64'(d8), 64'd0);
    chk("rst_busy8", 64'(bz8), 64'd0);
    chk("rst_err8", 64'(e8), 64'd0);
    chk("rst_res8", 64'(r8), 64'd0);
    chk("rst_res16", 64'(r16), 64'd0);

    chk("pin_sub", 64'(ref_res(8, 4'd3, 5, 7)), 64'hFFFE);
    chk("pin_4ab", 64'(ref_res(8, 4'd10, 3, 2)), 64'd21);
    chk("pin_shr", 64'(ref_res(8, 4'd8, 8'h81, 0)), 64'h40);
    chk("pin_mul16", 64'(ref_res(16, 4'd4, 16'hFFFF, 16'hFFFF)), 64'hFFFE0001);
    reset_n = 1'b1;
    tick();

    go8(4'd1, 8'd200, 8'd100, 1'b0, lat, nb);
    chk("add_lat", 64'(lat), 64'd1);
    chk("add_busy", 64'(nb), 64'd0);
    chk("add_res", 64'(r8), 64'h012C);
    chk("add_err", 64'(e8), 64'd0);

    go8(4'd3, 8'd5, 8'd7, 1'b0, lat, nb);
    chk("sub_lat", 64'(lat), 64'd1);
    chk("sub_res", 64'(r8), 64'hFFFE);
    go8(4'd7, 8'h81, 8'h00, 1'b0, lat, nb);
    chk("shl_lat", 64'(lat), 64'd1);
    chk("shl_res", 64'(r8), 64'h0102);

    go8(4'd4, 8'd255, 8'd255, 1'b1, lat, nb);
    chk("mul_lat", 64'(lat), 64'd3);
    chk("mul_busy", 64'(nb), 64'd2);
    chk("mul_res", 64'(r8), 64'hFE01);
    tick();
    chk("mul_no_extra", 64'(d8), 64'd0);
    chk("mul_hold", 64'(r8), 64'hFE01);

    go8(4'd10, 8'd3, 8'd2, 1'b0, lat, nb);
    chk("op10_res", 64'(r8), 64'd21);
    go8(4'd10, 8'd5, 8'd6, 1'b0, lat, nb);
    chk("chain_gap", 64'(lat), 64'd3);
    chk("chain_res", 64'(r8), 64'd115);
    go8(4'd9, 8'd2, 8'd1, 1'b0, lat, nb);
    chk("op9_res", 64'(r8), 64'd0);
    go8(4'd12, 8'd255, 8'd0, 1'b0, lat, nb);
    chk("op12_res", 64'(r8), 64'd765);

    go8(4'd15, 8'd9, 8'd9, 1'b0, lat, nb);
    chk("ill_lat", 64'(lat), 64'd1);
    chk("ill_err", 64'(e8), 64'd1);
    chk("ill_res", 64'(r8), 64'd0);
    go8(4'd2, 8'hF0, 8'h3C, 1'b0, lat, nb);
    chk("and_err", 64'(e8), 64'd0);
    chk("and_res", 64'(r8), 64'h0030);

    put8(1'b1, 4'd4, 8'd9, 8'd9);
    @(posedge clk);
    put8(1'b0, 4'd0, 8'd0, 8'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_done", 64'(d8), 64'd0);
    chk("arst_busy", 64'(bz8), 64'd0);
    chk("arst_err", 64'(e8), 64'd0);
    chk("arst_res", 64'(r8), 64'd0);
    tick();
    put8(1'b1, 4'd1, 8'd3, 8'd3);
    tick();
    reset_n = 1'b1;
    tick();
    chk("rel_done", 64'(d8), 64'd1);
    chk("rel_res", 64'(r8), 64'd6);
    put8(1'b0, 4'd0, 8'd0, 8'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rel_no_ghost", 64'(d8), 64'd0);
    end

    go16(4'd4, 16'hFFFF, 16'hFFFF, lat, nb);
    chk("mul16_lat", 64'(lat), 64'd5);
    chk("mul16_busy", 64'(nb), 64'd4);
    chk("mul16_res", 64'(r16), 64'hFFFE0001);
    go16(4'd1, 16'hFFFF, 16'h0001, lat, nb);
    chk("add16_res", 64'(r16), 64'h00010000);

    for (int i = 0; i < 800; i++) begin
      tick();
      if (i == 400) begin
        @(posedge clk);
        #2 reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
      end
      put8($urandom_range(0, 99) < 45, 4'($urandom),
           8'($urandom), 8'($urandom));
      put16($urandom_range(0, 99) < 45, 4'($urandom),
            16'($urandom), 16'($urandom));
    end
    put8(1'b0, 4'd0, 8'd0, 8'd0);
    put16(1'b0, 4'd0, 16'd0, 16'd0);
    repeat (8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_pipe_param.md
ALU_PIPE_PARAM -- requirements
Module: alu_pipe_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..32.
REQ-002 The block SHALL have parameter MULT_LAT, default 3, giving the multi-cycle op latency in cycles; legal range 2..8.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, operation request.
REQ-006 The block SHALL have port opcode, input, 4, operation select.
REQ-007 The block SHALL have ports A and B, input, WIDTH each, unsigned operands.
REQ-008 The block SHALL have port done, output, 1, one-cycle completion pulse.
REQ-009 The block SHALL have port busy, output, 1, high while a multi-cycle op is in flight.
REQ-010 The block SHALL have port err, output, 1, illegal-opcode flag, valid with done.
REQ-011 The block SHALL have port result, output, 2*WIDTH, operation result.

Function
REQ-012 The block SHALL accept a request at a rising edge where start=1 and busy=0, and call that edge E0.
REQ-013 The block SHALL capture A, B and opcode at E0; later input changes SHALL NOT affect that operation.
REQ-014 The block SHALL ignore start=1 while busy=1: no capture, no extra done.
REQ-015 The block SHALL use latency L=1 for opcodes 0000 NOP (result 0), 0001 A+B, 0010 A&B, 0011 A-B, 0101 A^B, 0110 A|B, 0111 A<<1, 1000 A>>1.
REQ-016 The block SHALL use latency L=MULT_LAT for opcodes 0100 A*B, 1001 A*B-A, 1010 4*A*B-A, 1011 A*B+A, 1100 3*A.
REQ-017 The block SHALL treat opcodes 1101..1111 as illegal with L=1, result 0 and err=1.
REQ-018 The block SHALL zero-extend operands to 2*WIDTH bits and compute all results modulo 2^(2*WIDTH); subtraction wraps as two's complement (e.g. 5-7 gives all-ones except LSB).
REQ-019 The block SHALL keep shifts WIDTH-bit-exact before extension: A<<1 keeps bit WIDTH (no loss), A>>1 shifts a zero into the MSB.
REQ-020 The block SHALL update result and raise done for exactly one cycle after edge E0+L-1.
REQ-021 The block SHALL hold err with done and keep both valid until the next completion.
REQ-022 The block SHALL hold result stable after done until the next completion; it SHALL NOT return to zero when start drops.
REQ-023 The block SHALL implement the FSM states IDLE and EXEC with these transitions:
- IDLE to EXEC on acceptance of a multi-cycle op, loading a down-counter with MULT_LAT-1.
- EXEC decrements the counter each edge; at count 1 it returns to IDLE and pulses done.
- single-cycle ops complete from IDLE without leaving it.
REQ-024 The block SHALL drive busy=1 exactly while the FSM is in EXEC (L-1 cycles for a multi-cycle op).
REQ-025 The block SHALL drive busy=0 throughout single-cycle ops, so back-to-back single-cycle requests each complete in consecutive cycles.
REQ-026 The block SHALL accept a start that arrives in the same cycle as done (busy=0 then), giving zero-bubble chaining.
REQ-027 The block SHALL NOT require start to be held; a one-cycle start pulse is sufficient.
REQ-028 The block SHALL flag an out-of-range WIDTH or MULT_LAT at elaboration.

Reset
REQ-029 The block SHALL, on reset_n=0 and without waiting for clk, force state IDLE, counter 0, done=0, busy=0, err=0 and result=0.
REQ-030 The block SHALL discard any operation in flight at reset; no done follows reset release.
REQ-031 The block SHALL ignore start while reset_n=0 and accept it from the first rising edge with reset_n=1.

Verification (WIDTH=8, MULT_LAT=3 unless stated)
REQ-032 The bench SHALL cover: op 0001, A=200, B=100, one-cycle start -> done after E0, result=0x012C, err=0, busy never high.
REQ-033 The bench SHALL cover: op 0011, A=5, B=7 -> result=0xFFFE one cycle later; then op 0111, A=0x81 next cycle -> result=0x0102 in the following cycle.
REQ-034 The bench SHALL cover: op 0100, A=B=255 -> busy high 2 cycles, done after E0+2, result=0xFE01; a start with op 0001 issued during busy -> ignored.
REQ-035 The bench SHALL cover the special ops:
- 1010, A=3, B=2 -> result=21.
- 1001, A=2, B=1 -> result=0.
- 1100, A=255 -> result=765.
- 1010 chained in the done cycle -> second done exactly 3 cycles after the first.
REQ-036 The bench SHALL cover: op 1111 -> done after one cycle, err=1, result=0; next op 0010, A=0xF0, B=0x3C -> err=0, result=0x0030.
REQ-037 The bench SHALL cover: reset_n=0 one cycle into op 0100 -> all outputs 0 immediately, no done after release.
REQ-038 The bench SHALL cover: repeat REQ-034 with WIDTH=16, MULT_LAT=5, A=B=0xFFFF -> result=0xFFFE0001 after 5 cycles.
